// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: a registered divided clock plus rise/fall strobes.
// Half-period updates are taken over a valid/ready slot and applied only on a falling boundary.
module clk_div_ctrl #(
    parameter int          CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = 4999
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_half
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             full_q, full_d;
    logic             tc;
    logic             xfer;

    assign tc   = (cnt_q == cur_q);
    assign xfer = cfg_valid && !full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cur_d   = cur_q;
        pend_d  = pend_q;
        full_d  = full_q;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (full_q) begin
                    cur_d  = pend_q;
                    full_d = 1'b0;
                end
                if (en) state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                if (!en && !clk_q) begin
                    // Low phase may be cut short; no edge is produced on the way out.
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    if (tc) begin
                        cnt_d  = '0;
                        clk_d  = !clk_q;
                        rise_d = !clk_q;
                        fall_d = clk_q;
                        if (clk_q && full_q) begin
                            cur_d  = pend_q;
                            full_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (en)
                        state_d = ST_RUN;
                    else if (tc)
                        state_d = ST_STOP;
                    else
                        state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        // Only possible while the slot is empty, so never collides with a release above.
        if (xfer) begin
            pend_d = cfg_half;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cur_q   <= CNT_W'(DEFAULT_HALF);
            pend_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
        end
    end

    assign cfg_ready = !full_q;
    assign clk_out   = clk_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign running   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cur_half  = cur_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a small default half-period so whole waveforms are short.
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;

    logic             clk_in;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic             running;
    logic [CNT_W-1:0] cur_half;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .running   (running),
        .cur_half  (cur_half)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n sampled cycles at level lvl; with tick set, the first sample must carry the edge strobe.
    task automatic phase(input int n, input logic lvl, input logic tick, input logic run,
                         input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            chk({tag, ".clk"},  {31'd0, clk_out},   {31'd0, lvl});
            chk({tag, ".rise"}, {31'd0, rise_tick}, {31'd0, tick && lvl && (i == 0)});
            chk({tag, ".fall"}, {31'd0, fall_tick}, {31'd0, tick && !lvl && (i == 0)});
            chk({tag, ".run"},  {31'd0, running},   {31'd0, run});
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (!rst) begin
            n_cmp++;
            assert (!(rise_tick && fall_tick)) else begin
                n_bad++;
                $error("FAIL tick_excl: observed both ticks high expected at most one");
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
        step();
        chk("rst.clk",   {31'd0, clk_out},   32'd0);
        chk("rst.rise",  {31'd0, rise_tick}, 32'd0);
        chk("rst.fall",  {31'd0, fall_tick}, 32'd0);
        chk("rst.run",   {31'd0, running},   32'd0);
        chk("rst.half",  {16'd0, cur_half},  32'd4);
        chk("rst.ready", {31'd0, cfg_ready}, 32'd1);

        // startup and steady run at half 4
        rst = 1'b0; en = 1'b1;
        phase(5, 1'b0, 1'b0, 1'b1, "s1_lo0");
        phase(5, 1'b1, 1'b1, 1'b1, "s1_hi0");
        phase(5, 1'b0, 1'b1, 1'b1, "s1_lo1");
        phase(5, 1'b1, 1'b1, 1'b1, "s1_hi1");
        phase(5, 1'b0, 1'b1, 1'b1, "s1_lo2");

        // reconfigure to half 1 during a high phase
        phase(1, 1'b1, 1'b1, 1'b1, "s2_hi");
        cfg_valid = 1'b1; cfg_half = 16'd1;
        phase(1, 1'b1, 1'b0, 1'b1, "s2_xfer");
        chk("s2_xfer.ready", {31'd0, cfg_ready}, 32'd0);
        chk("s2_xfer.half",  {16'd0, cur_half},  32'd4);
        cfg_valid = 1'b0;
        phase(3, 1'b1, 1'b0, 1'b1, "s2_hold");
        chk("s2_hold.ready", {31'd0, cfg_ready}, 32'd0);
        phase(1, 1'b0, 1'b1, 1'b1, "s2_fall");
        chk("s2_fall.half",  {16'd0, cur_half},  32'd1);
        chk("s2_fall.ready", {31'd0, cfg_ready}, 32'd1);
        phase(1, 1'b0, 1'b0, 1'b1, "s2_lo");
        phase(2, 1'b1, 1'b1, 1'b1, "s2_hi1");
        phase(2, 1'b0, 1'b1, 1'b1, "s2_lo1");
        phase(2, 1'b1, 1'b1, 1'b1, "s2_hi2");

        // transfer on the same edge as a fall waits for the next fall
        cfg_valid = 1'b1; cfg_half = 16'd4;
        phase(1, 1'b0, 1'b1, 1'b1, "sc_fall");
        chk("sc_fall.half",  {16'd0, cur_half},  32'd1);
        chk("sc_fall.ready", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        phase(1, 1'b0, 1'b0, 1'b1, "sc_lo");
        phase(2, 1'b1, 1'b1, 1'b1, "sc_hi");
        phase(1, 1'b0, 1'b1, 1'b1, "sc_apply");
        chk("sc_apply.half",  {16'd0, cur_half},  32'd4);
        chk("sc_apply.ready", {31'd0, cfg_ready}, 32'd1);
        phase(4, 1'b0, 1'b0, 1'b1, "sc_lo4");

        // disable in a high phase drains it fully; disable in a low phase stops at once
        phase(1, 1'b1, 1'b1, 1'b1, "s3_hi");
        en = 1'b0;
        phase(4, 1'b1, 1'b0, 1'b1, "s3_drain");
        phase(1, 1'b0, 1'b1, 1'b0, "s3_fall");
        phase(3, 1'b0, 1'b0, 1'b0, "s3_stop");
        en = 1'b1;
        phase(3, 1'b0, 1'b0, 1'b1, "s3_run");
        en = 1'b0;
        phase(6, 1'b0, 1'b0, 1'b0, "s3_lostop");

        // short en glitch in a high phase leaves the waveform untouched
        en = 1'b1;
        phase(5, 1'b0, 1'b0, 1'b1, "s4_lo0");
        phase(1, 1'b1, 1'b1, 1'b1, "s4_hi");
        en = 1'b0;
        phase(2, 1'b1, 1'b0, 1'b1, "s4_drain");
        en = 1'b1;
        phase(2, 1'b1, 1'b0, 1'b1, "s4_back");
        phase(5, 1'b0, 1'b1, 1'b1, "s4_lo1");
        phase(5, 1'b1, 1'b1, 1'b1, "s4_hi1");
        phase(1, 1'b0, 1'b1, 1'b1, "s4_lo2");
        en = 1'b0;
        phase(2, 1'b0, 1'b0, 1'b0, "s4_stop");

        // divide by 2
        cfg_valid = 1'b1; cfg_half = 16'd0;
        step();
        chk("s5_xfer.ready", {31'd0, cfg_ready}, 32'd0);
        chk("s5_xfer.half",  {16'd0, cur_half},  32'd4);
        cfg_valid = 1'b0; en = 1'b1;
        step();
        chk("s5_apply.half",  {16'd0, cur_half},  32'd0);
        chk("s5_apply.ready", {31'd0, cfg_ready}, 32'd1);
        chk("s5_apply.clk",   {31'd0, clk_out},   32'd0);
        chk("s5_apply.run",   {31'd0, running},   32'd1);
        phase(1, 1'b1, 1'b1, 1'b1, "s5_a");
        phase(1, 1'b0, 1'b1, 1'b1, "s5_b");
        phase(1, 1'b1, 1'b1, 1'b1, "s5_c");
        phase(1, 1'b0, 1'b1, 1'b1, "s5_d");
        en = 1'b0;
        phase(2, 1'b0, 1'b0, 1'b0, "s5_stop");

        // maximum half-period accepted and counting without an early edge
        cfg_valid = 1'b1; cfg_half = 16'hFFFF;
        step();
        cfg_valid = 1'b0;
        step();
        chk("max.half",  {16'd0, cur_half},  32'h0000FFFF);
        chk("max.ready", {31'd0, cfg_ready}, 32'd1);
        en = 1'b1;
        phase(20, 1'b0, 1'b0, 1'b1, "max_lo");
        en = 1'b0;
        phase(1, 1'b0, 1'b0, 1'b0, "max_stop");

        // async reset while a rise strobe and a pending config are live
        cfg_valid = 1'b1; cfg_half = 16'd2;
        step();
        cfg_valid = 1'b0;
        step();
        chk("s6_prep.half", {16'd0, cur_half}, 32'd2);
        en = 1'b1;
        phase(1, 1'b0, 1'b0, 1'b1, "s6_lo0");
        cfg_valid = 1'b1; cfg_half = 16'd7;
        phase(1, 1'b0, 1'b0, 1'b1, "s6_lo1");
        chk("s6_pend.ready", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        phase(1, 1'b0, 1'b0, 1'b1, "s6_lo2");
        phase(1, 1'b1, 1'b1, 1'b1, "s6_hi");
        #1 rst = 1'b1;
        #1;
        chk("s6_rst.clk",   {31'd0, clk_out},   32'd0);
        chk("s6_rst.rise",  {31'd0, rise_tick}, 32'd0);
        chk("s6_rst.fall",  {31'd0, fall_tick}, 32'd0);
        chk("s6_rst.run",   {31'd0, running},   32'd0);
        chk("s6_rst.half",  {16'd0, cur_half},  32'd4);
        chk("s6_rst.ready", {31'd0, cfg_ready}, 32'd1);
        step();
        rst = 1'b0;
        phase(5, 1'b0, 1'b0, 1'b1, "s6_lo0b");
        phase(5, 1'b1, 1'b1, 1'b1, "s6_hi0b");
        phase(5, 1'b0, 1'b1, 1'b1, "s6_lo1b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
